arb_mux4: RTL
=============

# arb_mux4

Four-way round-robin arbiter that shares a single `mux4` 4-to-1 selector between four requesters. It grants exactly one requester at a time and drives the mux select lines from the winning index. Each grant is capped by a quantum, so one requester cannot starve the others. The block sits directly in front of `mux4`: `sel` drives the mux select port, and `gnt` returns to the requesters.

## Interface
- `QUANTUM`, default 4: maximum consecutive grant cycles per owner while others wait. Legal range 2..(2^QW).
- `QW`, default 3: width of the internal grant-cycle counter. Must satisfy 2^QW ≥ QUANTUM.
- `clk` input, 1 bit: single clock. Everything is sampled on its rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `req` input, 4 bits: request vector. `req[i]=1` means requester i wants the mux.
- `gnt` output, 4 bits: registered grant vector, one-hot or all-zero.
- `sel` output, 2 bits: registered mux select, equal to the index of the current or most recent owner.
- `busy` output, 1 bit: registered. Equals 1 exactly when `gnt` is non-zero.
- `expire` output, 1 bit: registered, one-cycle pulse. Asserted in the cycle after a grant was revoked by quantum expiry.

## Operation
- State machine has two states: IDLE (no owner) and GRANT (owner = `sel`).
- Internal state:
  - `last`: 2-bit round-robin pointer; the index of the last owner.
  - `cnt`: QW-bit counter of cycles the current owner has held the grant.
- Search order at any decision point: `last+1`, `last+2`, `last+3`, `last` (all mod 4). The first requester in this order with `req` set wins.
- IDLE:
  - If `req`==0: stay in IDLE; `gnt`=0, `busy`=0, `sel` holds its previous value.
  - Otherwise: load the winner w into `gnt` (one-hot), `sel`=w, `last`=w, `cnt`=0, `busy`=1, and go to GRANT.
- GRANT with owner o, evaluated each edge in the priority order below:
  1. `req[o]`=0 (voluntary release): pick a winner among the remaining requests. If one exists, switch directly with no idle cycle and `cnt`=0. If none, go to IDLE with `gnt`=0 and `busy`=0.
  2. `cnt`==QUANTUM-1 and another `req[j]`=1 (j≠o): revoke the grant from o, grant the next winner in search order from o+1, set `cnt`=0, and pulse `expire`=1.
  3. `cnt`==QUANTUM-1 and no other requester: o keeps the grant, and `cnt` wraps to 0. No expiry pulse.
  4. Otherwise: hold the grant and increment `cnt`.
- Requests are level-sensitive. There are no priorities beyond the round-robin order, and no fixed starvation window other than the quantum.
- Worst-case wait for a continuously requesting requester: 3×QUANTUM cycles plus 1.

## Timing
- Reset, asynchronous, takes effect immediately on `reset`=1:
  - Outputs: `gnt`=0000, `sel`=00, `busy`=0, `expire`=0.
  - Internal: `last`=3 (so index 0 has first priority after reset), `cnt`=0, state IDLE.
- Reset mid-grant: the grant is dropped immediately without waiting for a clock edge. After `reset` deasserts, the block restarts from IDLE.
- Grant latency:
  - `req` seen at edge k → `gnt` valid after edge k (one cycle from request to grant).
  - Release: `req[o]` low at edge k → `gnt[o]` low after edge k. The new owner's grant appears at that same edge.
- All outputs are registered, with no combinational path from `req` to any output.
- `sel` and `gnt` change on the same edge, so `sel` always matches `gnt` whenever `busy`=1.
- `expire` is high for exactly one cycle, coincident with the first grant cycle of the new owner.
- Simultaneous events:
  - Release and quantum expiry on the same edge count as a release (`expire`=0).
  - A new request arriving on the same edge as a release is considered in that edge's search.
- Max continuous hold under contention: exactly QUANTUM cycles of `gnt[o]`=1.

## Test plan
- **Reset:** assert `reset` mid-grant with `req`=1111.
  - Required: `gnt`=0000, `sel`=00, `busy`=0 immediately.
  - After release of `reset` with `req`=1111: first grant is `gnt`=0001.
- **Single requester:** hold `req`=0100 for 10 cycles.
  - Required: `gnt`=0100 and `sel`=10 one cycle after the request, held for all 10 cycles.
  - `expire` never asserts.
- **Full contention:** hold `req`=1111 with QUANTUM=4.
  - Required: grants rotate 0001→0010→0100→1000→0001, each lasting exactly 4 cycles.
  - `expire` pulses at each switch.
- **Voluntary release:** owner 1 with `req`=1010; drop `req[1]` after 2 cycles.
  - Required: `gnt` goes 0010→1000 on the same edge, with no idle cycle and `expire`=0.
- **Return to idle:** `req`=0001 for 3 cycles, then 0000.
  - Required: `gnt`=0000 and `busy`=0 on the next edge; `sel` holds 00.
  - A later `req`=1001 grants index 3 first, because `last`=0.
- **Mux integration:** drive `sel` into `mux4` with data inputs a=0, b=1, c=0, d=1 under `req`=1111.
  - Required: mux output follows 0,1,0,1 as the owner rotates through indices 0, 1, 2, 3.

Source files
------------

// File: rtl/arb_mux4.sv
// Four-way round-robin arbiter with a per-owner grant quantum, plus the mux4
// selector it steers through sel.

module mux4 #(
    parameter int W = 1
) (
    input  logic [W-1:0] i_d0,
    input  logic [W-1:0] i_d1,
    input  logic [W-1:0] i_d2,
    input  logic [W-1:0] i_d3,
    input  logic [1:0]   i_sel,
    output logic [W-1:0] o_y
);
    always_comb begin
        unique case (i_sel)
            2'd0:    o_y = i_d0;
            2'd1:    o_y = i_d1;
            2'd2:    o_y = i_d2;
            default: o_y = i_d3;
        endcase
    end
endmodule

module arb_mux4 #(
    parameter int QUANTUM = 4,
    parameter int QW      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       expire
);
    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t        r_state;
    logic [1:0]    r_last;
    logic [QW-1:0] r_cnt;
    logic [3:0]    r_gnt;
    logic [1:0]    r_sel;
    logic          r_busy;
    logic          r_expire;

    logic [3:0]    w_rot;
    logic [1:0]    w_off;
    logic [1:0]    w_win;
    logic          w_found;
    logic [3:0]    w_win_onehot;
    logic [3:0]    w_own_mask;
    logic          w_req_own;
    logic          w_others;
    logic          w_quantum_end;

    // w_rot[k] is the request of index last+1+k, so the lowest set bit is the
    // round-robin winner; the current owner (== last) is naturally searched last.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign w_rot[gi] = req[r_last + 2'(gi + 1)];
        end
    endgenerate

    always_comb begin
        w_off = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (w_rot[k]) w_off = 2'(k);
        end
    end

    assign w_found       = |w_rot;
    assign w_win         = r_last + 2'd1 + w_off;
    assign w_win_onehot  = 4'b0001 << w_win;
    assign w_own_mask    = 4'b0001 << r_last;
    assign w_req_own     = |(req & w_own_mask);
    assign w_others      = |(req & ~w_own_mask);
    assign w_quantum_end = (r_cnt == QW'(QUANTUM - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_last   <= 2'd3;
            r_cnt    <= '0;
            r_gnt    <= 4'b0000;
            r_sel    <= 2'd0;
            r_busy   <= 1'b0;
            r_expire <= 1'b0;
        end else begin
            r_expire <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt   <= w_win_onehot;
                        r_sel   <= w_win;
                        r_last  <= w_win;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (!w_req_own) begin
                        // Release wins over expiry; hand over with no idle gap.
                        if (w_found) begin
                            r_gnt  <= w_win_onehot;
                            r_sel  <= w_win;
                            r_last <= w_win;
                            r_cnt  <= '0;
                        end else begin
                            r_gnt   <= 4'b0000;
                            r_busy  <= 1'b0;
                            r_cnt   <= '0;
                            r_state <= S_IDLE;
                        end
                    end else if (w_quantum_end && w_others) begin
                        r_gnt    <= w_win_onehot;
                        r_sel    <= w_win;
                        r_last   <= w_win;
                        r_cnt    <= '0;
                        r_expire <= 1'b1;
                    end else if (w_quantum_end) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + QW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt    = r_gnt;
    assign sel    = r_sel;
    assign busy   = r_busy;
    assign expire = r_expire;

endmodule
